// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// with a combinational stall request and a one-cycle registered result.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ex_muldiv_opcode_i,
  input  logic [2:0]  ex_muldiv_funct3_i,
  input  logic [6:0]  ex_muldiv_funct7_i,
  input  logic [4:0]  ex_muldiv_rd_i,
  input  logic [31:0] ex_muldiv_rs1_reg_data_i,
  input  logic [31:0] ex_muldiv_rs2_reg_data_i,
  input  logic        ex_muldiv_pipeline_flush_flag,
  output logic        ex_muldiv_stall_req_o,
  output logic        ex_muldiv_valid_o,
  output logic [31:0] ex_muldiv_result_o,
  output logic [4:0]  ex_muldiv_rd_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] Funct7Muldiv = 7'b0000001;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        neg_q, neg_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;

  logic        is_m, flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic        rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [31:0] rs1_mag, rs2_mag;
  logic        div_by_zero, div_ovf, start_neg;
  logic [31:0] special_result;

  assign f3    = ex_muldiv_funct3_i;
  assign rs1   = ex_muldiv_rs1_reg_data_i;
  assign rs2   = ex_muldiv_rs2_reg_data_i;
  assign flush = ex_muldiv_pipeline_flush_flag;
  assign is_m  = (ex_muldiv_opcode_i == OpcodeOp) && (ex_muldiv_funct7_i == Funct7Muldiv);

  // Multiplies: rs1 signed for MUL/MULH/MULHSU, rs2 for MUL/MULH. Divides: signed when f3[0]=0.
  assign rs1_signed = f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  assign rs2_signed = f3[2] ? ~f3[0] : ~f3[1];
  assign rs1_neg    = rs1_signed & rs1[31];
  assign rs2_neg    = rs2_signed & rs2[31];
  assign rs1_mag    = rs1_neg ? -rs1 : rs1;
  assign rs2_mag    = rs2_neg ? -rs2 : rs2;

  assign div_by_zero = f3[2] && (rs2 == 32'd0);
  assign div_ovf     = f3[2] && !f3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  // Remainder follows the dividend; everything else is negated when the signs differ.
  assign start_neg   = (f3[2] && f3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);

  always_comb begin
    special_result = 32'd0;
    if (div_by_zero) begin
      special_result = f3[1] ? rs1 : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_result = f3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Shared datapath: acc holds {product_hi, multiplier} or {remainder, quotient}.
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_signed;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
  logic [31:0] mul_res, div_res, div_sel;

  assign mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next   = {mul_sum, acc_q[31:1]};
  assign mul_signed = neg_q ? -mul_next : mul_next;
  assign mul_res    = (funct3_q[1:0] == 2'b00) ? mul_signed[31:0] : mul_signed[63:32];

  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};
  assign div_sel   = funct3_q[1] ? div_next[63:32] : div_next[31:0];
  assign div_res   = neg_q ? -div_sel : div_sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    rd_lat_d = rd_lat_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      StIdle: begin
        if (is_m && !flush) begin
          funct3_d = f3;
          neg_d    = start_neg;
          rd_lat_d = ex_muldiv_rd_i;
          cnt_d    = 5'd0;
          if (div_by_zero || div_ovf) begin
            state_d  = StDone;
            result_d = special_result;
            rd_d     = ex_muldiv_rd_i;
          end else if (f3[2]) begin
            state_d = StDiv;
            acc_d   = {32'd0, rs1_mag};
            opb_d   = rs2_mag;
          end else begin
            state_d = StMul;
            acc_d   = {32'd0, rs2_mag};
            opb_d   = rs1_mag;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = mul_res;
          rd_d     = rd_lat_q;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = div_res;
          rd_d     = rd_lat_q;
        end
      end
      default: begin
        state_d  = StIdle;
        result_d = 32'd0;
        rd_d     = 5'd0;
      end
    endcase
    // Flush aborts: no result is loaded for the dropped operation.
    if (flush) begin
      state_d = StIdle;
      cnt_d   = 5'd0;
      if (state_q != StDone) begin
        result_d = result_q;
        rd_d     = rd_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      funct3_q <= 3'd0;
      neg_q    <= 1'b0;
      rd_lat_q <= 5'd0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      rd_lat_q <= rd_lat_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign ex_muldiv_stall_req_o = ((state_q == StIdle && is_m) || state_q == StMul ||
                                  state_q == StDiv) && !flush;
  assign ex_muldiv_valid_o     = (state_q == StDone);
  assign ex_muldiv_result_o    = result_q;
  assign ex_muldiv_rd_o        = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed results, latency, flush and reset abort.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_in;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] OpM   = 7'b0110011;
  localparam logic [6:0] F7M   = 7'b0000001;
  localparam logic [6:0] OpImm = 7'b0010011;

  ex_muldiv dut (
    .clk                           (clk),
    .rst                           (rst),
    .ex_muldiv_opcode_i            (opcode),
    .ex_muldiv_funct3_i            (funct3),
    .ex_muldiv_funct7_i            (funct7),
    .ex_muldiv_rd_i                (rd_in),
    .ex_muldiv_rs1_reg_data_i      (rs1),
    .ex_muldiv_rs2_reg_data_i      (rs2),
    .ex_muldiv_pipeline_flush_flag (flush),
    .ex_muldiv_stall_req_o         (stall),
    .ex_muldiv_valid_o             (valid),
    .ex_muldiv_result_o            (result),
    .ex_muldiv_rd_o                (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one M instruction at cycle T and check stall/valid/result through T+lat+1.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat);
    @(negedge clk);
    opcode = OpM; funct7 = F7M; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
    #1 chk({tag, " stall@T"}, {31'd0, stall}, 32'd1);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      opcode = OpImm;
      #1 chk({tag, " busy"}, {30'd0, stall, valid}, 32'd2);
    end
    @(negedge clk);
    opcode = OpImm;
    #1;
    chk({tag, " valid"}, {30'd0, valid, stall}, 32'd2);
    chk({tag, " result"}, result, exp);
    chk({tag, " rd"}, {27'd0, rd_out}, {27'd0, rd});
    @(negedge clk);
    #1;
    chk({tag, " after"}, {31'd0, valid}, 32'd0);
    chk({tag, " result clr"}, result, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    opcode = OpImm; funct3 = 3'd0; funct7 = 7'd0; rd_in = 5'd0; rs1 = 32'd0; rs2 = 32'd0;
    #12;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
    run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
    run_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,         5'd11, 32'd14,        33);
    run_op("REMU 100/7",     3'b111, 32'd100,        32'd7,         5'd0,  32'd2,         33);
    run_op("DIVU 5/0",       3'b101, 32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, 1);
    run_op("REM 5/0",        3'b110, 32'd5,          32'd0,         5'd13, 32'd5,         1);
    run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         1);

    // Flush at T+10 during a multiply.
    @(negedge clk);
    opcode = OpM; funct7 = F7M; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; rd_in = 5'd3;
    @(negedge clk);
    opcode = OpImm;
    repeat (8) @(negedge clk);
    #1 chk("flush pre stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1 chk("flush quiet", {30'd0, stall, valid}, 32'd0);
      @(negedge clk);
    end
    run_op("MUL after flush", 3'b000, 32'd3, 32'd4, 5'd3, 32'd12, 33);

    // Asynchronous reset at T+5 during a divide.
    @(negedge clk);
    opcode = OpM; funct7 = F7M; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd4;
    @(negedge clk);
    opcode = OpImm;
    repeat (3) @(negedge clk);
    #1 chk("rst pre stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1 chk("rst quiet", {30'd0, stall, valid}, 32'd0);
      @(negedge clk);
    end
    run_op("DIVU after rst", 3'b101, 32'd100, 32'd7, 5'd4, 32'd14, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It decodes M-extension R-type instructions from the registered decode fields and operand data, and runs a 32-step shift-add multiply or restoring divide. While busy it holds the front of the pipeline through a stall request to ctrl, then presents a one-cycle result to the EX/MEM path. Pipeline flush from ctrl aborts any operation in flight.

## Interface
- No parameters; data width fixed at 32, register address 5, opcode 7, funct3 3, funct7 7.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- ex_muldiv_opcode_i  in  7  registered opcode from ID/EX
- ex_muldiv_funct3_i  in  3  registered funct3
- ex_muldiv_funct7_i  in  7  registered funct7
- ex_muldiv_rd_i  in  5  destination register address
- ex_muldiv_rs1_reg_data_i  in  32  rs1 operand
- ex_muldiv_rs2_reg_data_i  in  32  rs2 operand
- ex_muldiv_pipeline_flush_flag  in  1  flush from ctrl; aborts the operation
- ex_muldiv_stall_req_o  out  1  hold IF/ID/EX stages; combinational
- ex_muldiv_valid_o  out  1  result valid, one-cycle pulse
- ex_muldiv_result_o  out  32  result; 0 when not valid
- ex_muldiv_rd_o  out  5  destination of the result

## Operation
- M instruction: opcode 7'b0110011 and funct7 7'b0000001.
- funct3 mapping:
  - 000 MUL (low 32 bits of product)
  - 001 MULH (high 32 bits, signed×signed)
  - 010 MULHSU (high 32 bits, signed rs1 × unsigned rs2)
  - 011 MULHU (high 32 bits, unsigned×unsigned)
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- States:
  - IDLE: an M instruction with flush low is accepted at the clock edge. Operands are converted to magnitudes per signedness, and funct3, rd and the result sign are latched. Next state is MUL, or DIV; divide special cases go straight to DONE.
  - MUL: one shift-add step per cycle on 32-bit magnitudes into a 64-bit accumulator. A 5-bit counter runs 0..31; at 31 the state moves to DONE.
  - DIV: one restoring step per cycle (shift remainder, trial-subtract divisor, set quotient bit). The same counter is used; at 31 the state moves to DONE.
  - DONE: valid_o=1. result_o is the selected half, quotient or remainder, two's-complement negated if the latched sign is set. Next state is always IDLE. No new instruction is accepted in DONE.
- Sign rules:
  - Product is negated when the operand signs differ (signed operands only).
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Divide special cases (1-cycle latency):
  - Divisor 0: quotient 0xFFFFFFFF; remainder = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- stall_req_o = (IDLE & M instruction | MUL | DIV) & ~flush. It is low in DONE, so the pipeline advances at the end of DONE.
- Flush in any state: next state IDLE and counter cleared. valid_o is not asserted for the aborted operation.
- Non-M instruction in IDLE: no action, stall low, valid low.
- rd=0 is computed normally; discarding the result is writeback's job.
- Reset: state IDLE, counter 0, accumulators 0, valid_o 0, result_o 0, rd_o 0, stall_req_o 0.

## Timing
- Instruction present in IDLE at cycle T:
  - stall_req_o is high in T (combinational).
  - MUL/DIV state occupies T+1..T+32.
  - DONE at T+33: valid_o=1 for exactly that cycle, stall low.
  - The next instruction can be accepted in IDLE at T+34.
- Special-case divide: stall high in T only, DONE at T+1.
- result_o and rd_o are registered and change only on entry to DONE. They return to 0 the cycle after DONE.
- Flush and DONE in the same cycle: valid_o still shows for that cycle; the next state is IDLE regardless.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). After release the unit is in IDLE; the aborted result is never produced.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD at cycle T -> stall high T..T+32; valid at T+33 with result 0xFFFFFFEB and rd_o = rd_i.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has 33-cycle latency.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. All three: valid at T+1, stall high only in T.
- Flush at T+10 during MUL -> stall low that cycle, state IDLE at T+11, no valid pulse. A following M instruction completes normally.
- rst pulse at T+5 during DIV -> all outputs 0 immediately; no valid after release. A back-to-back non-M instruction never raises stall.
